// File: rtl/testeio_mem_arb_pkg.sv
// Shared types and constants for the on-chip RAM port arbiter.
// Owner encoding, default widths and the hold-counter width helper.
package testeio_mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } owner_t;

  function automatic int unsigned hold_w(input int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/testeio_mem_arb_sel.sv
// Combinational master selection: hold-limited ownership with round-robin tie break.
module testeio_mem_arb_sel
  import testeio_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 3
) (
  input  owner_t            i_owner,
  input  logic [HOLD_W-1:0] i_hold_cnt,
  input  logic              i_rr_ptr,
  input  logic              i_req0,
  input  logic              i_req1,
  output logic              o_sel_vld,
  output logic              o_sel
);

  localparam logic [HOLD_W-1:0] MaxHoldC = HOLD_W'(MAX_HOLD);

  logic w_under_limit;

  assign w_under_limit = (i_hold_cnt < MaxHoldC);

  always_comb begin
    o_sel_vld = 1'b0;
    o_sel     = 1'b0;
    unique case (i_owner)
      OWN0: begin
        if (i_req0 && (w_under_limit || !i_req1)) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b0;
        end else if (i_req1) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b1;
        end else if (i_req0) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b0;
        end
      end
      OWN1: begin
        if (i_req1 && (w_under_limit || !i_req0)) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b1;
        end else if (i_req0) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b0;
        end else if (i_req1) begin
          o_sel_vld = 1'b1;
          o_sel     = 1'b1;
        end
      end
      default: begin
        if (i_req0 && i_req1) begin
          o_sel_vld = 1'b1;
          o_sel     = i_rr_ptr;
        end else if (i_req0 || i_req1) begin
          o_sel_vld = 1'b1;
          o_sel     = i_req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/testeio_mem_arbiter.sv
// Arbitrates two Avalon-MM masters onto one RAM port and routes
// the 1-cycle-latency read data back to the issuing master.
module testeio_mem_arbiter
  import testeio_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned HOLD_W = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] MaxHoldC = HOLD_W'(MAX_HOLD);

  owner_t            r_owner, w_owner_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              r_rr_ptr, w_rr_nxt;
  logic              r_rd_pend, w_rd_pend_nxt;
  logic              r_rd_who, w_rd_who_nxt;

  logic   w_req0, w_req1;
  logic   w_sel_vld, w_sel;
  logic   w_sel_rd, w_sel_wr;
  owner_t w_own_sel;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  testeio_mem_arb_sel #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_sel (
    .i_owner    (r_owner),
    .i_hold_cnt (r_hold_cnt),
    .i_rr_ptr   (r_rr_ptr),
    .i_req0     (w_req0),
    .i_req1     (w_req1),
    .o_sel_vld  (w_sel_vld),
    .o_sel      (w_sel)
  );

  assign w_sel_rd  = w_sel ? m1_read : m0_read;
  assign w_sel_wr  = w_sel ? m1_write : m0_write;
  assign w_own_sel = w_sel ? OWN1 : OWN0;

  // With nothing selected the m0 fields pass through as don't-care values.
  assign mem_chipselect = w_sel_vld;
  assign mem_write      = w_sel_vld & w_sel_wr;
  assign mem_address    = (w_sel_vld & w_sel) ? m1_address : m0_address;
  assign mem_byteenable = (w_sel_vld & w_sel) ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = (w_sel_vld & w_sel) ? m1_writedata : m0_writedata;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = w_req0 & ~(w_sel_vld & ~w_sel);
  assign m1_waitrequest = w_req1 & ~(w_sel_vld & w_sel);

  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  // Gated by reset so an outstanding read is dropped in the reset cycle itself.
  assign m0_readdatavalid = r_rd_pend & ~r_rd_who & ~reset;
  assign m1_readdatavalid = r_rd_pend & r_rd_who & ~reset;

  always_comb begin
    w_owner_nxt   = IDLE;
    w_hold_nxt    = '0;
    w_rr_nxt      = r_rr_ptr;
    w_rd_pend_nxt = w_sel_vld & w_sel_rd & ~w_sel_wr;
    w_rd_who_nxt  = w_sel;
    if (w_sel_vld) begin
      w_owner_nxt = w_own_sel;
      if (r_owner == w_own_sel) begin
        w_hold_nxt = (r_hold_cnt == MaxHoldC) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
      end else begin
        w_hold_nxt = HOLD_W'(1);
      end
      if ((r_owner != IDLE) && (r_owner != w_own_sel)) begin
        w_rr_nxt = ~w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= IDLE;
      r_hold_cnt <= '0;
      r_rr_ptr   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_who   <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_rd_pend  <= w_rd_pend_nxt;
      r_rd_who   <= w_rd_who_nxt;
    end
  end

endmodule

// File: tb/tb_testeio_mem_arbiter.sv
// Directed bench for testeio_mem_arbiter with a small byte-lane RAM model.
module tb_testeio_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  testeio_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // RAM model: registered address, unregistered output, preloaded while in reset.
  logic [31:0] ram [256];
  logic [7:0]  r_rd_addr = '0;

  always @(posedge clk) begin
    if (reset) begin
      ram[1]     <= 32'hA0A0_0001;
      ram[2]     <= 32'hB0B0_0002;
      ram[8'h20] <= 32'hCAFE_BABE;
    end else if (mem_chipselect) begin
      r_rd_addr <= mem_address[7:0];
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end

  assign mem_readdata = ram[r_rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g, prev;
    reset = 1'b1;
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_rdv0", m0_readdatavalid, 0);
    check_eq("rst_rdv1", m1_readdatavalid, 0);
    check_eq("rst_cs", mem_chipselect, 0);
    check_eq("rst_wait0", m0_waitrequest, 0);
    check_eq("clken", mem_clken, 1);

    // Single master write then read-back.
    set_m0(0, 1, 16'h0010, 4'hF, 32'hDEAD_BEEF);
    #1;
    check_eq("t1_wr_wait", m0_waitrequest, 0);
    check_eq("t1_wr_cs", mem_chipselect, 1);
    check_eq("t1_wr_we", mem_write, 1);
    check_eq("t1_wr_addr", mem_address, 32'h10);
    step();
    set_m0(1, 0, 16'h0010, 4'hF, 32'h0);
    #1;
    check_eq("t1_rd_wait", m0_waitrequest, 0);
    check_eq("t1_rd_we", mem_write, 0);
    check_eq("t1_rd_rdv_early", m0_readdatavalid, 0);
    step();
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("t1_rdv0", m0_readdatavalid, 1);
    check_eq("t1_data", m0_readdata, 32'hDEAD_BEEF);
    check_eq("t1_rdv1", m1_readdatavalid, 0);
    step();

    // Tie from reset, then both request continuously: 4 grants each in turn.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_m0(1, 0, 16'h0001, 4'hF, 32'h0);
    set_m1(1, 0, 16'h0002, 4'hF, 32'h0);
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      g = (i / 4) % 2;
      check_eq("hold_wait0", m0_waitrequest, (g == 1) ? 1 : 0);
      check_eq("hold_wait1", m1_waitrequest, (g == 0) ? 1 : 0);
      if (i > 0) begin
        check_eq("hold_rdv0", m0_readdatavalid, (prev == 0) ? 1 : 0);
        check_eq("hold_rdv1", m1_readdatavalid, (prev == 1) ? 1 : 0);
        check_eq("hold_data", m0_readdata, (prev == 1) ? 32'hB0B0_0002 : 32'hA0A0_0001);
      end
      prev = g;
      step();
    end
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("hold_last_rdv0", m0_readdatavalid, 1);
    check_eq("hold_last_data", m0_readdata, 32'hA0A0_0001);
    step();

    // Last switch was 1->0, so the next tie from idle favours m1.
    set_m0(1, 0, 16'h0001, 4'hF, 32'h0);
    set_m1(1, 0, 16'h0002, 4'hF, 32'h0);
    #1;
    check_eq("rr_wait0", m0_waitrequest, 1);
    check_eq("rr_wait1", m1_waitrequest, 0);
    check_eq("rr_addr", mem_address, 32'h2);
    step();
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("rr_rdv1", m1_readdatavalid, 1);
    step();

    // Alternating pipelined reads.
    set_m0(1, 0, 16'h0001, 4'hF, 32'h0);
    #1;
    check_eq("alt_wait0", m0_waitrequest, 0);
    step();
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    set_m1(1, 0, 16'h0002, 4'hF, 32'h0);
    #1;
    check_eq("alt_wait1", m1_waitrequest, 0);
    check_eq("alt_rdv0", m0_readdatavalid, 1);
    check_eq("alt_data0", m0_readdata, 32'hA0A0_0001);
    step();
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("alt_rdv1", m1_readdatavalid, 1);
    check_eq("alt_rdv0_off", m0_readdatavalid, 0);
    check_eq("alt_data1", m1_readdata, 32'hB0B0_0002);
    step();

    // Read+write together is a write with lanes 0-1 only.
    set_m1(1, 1, 16'h0020, 4'b0011, 32'h0000_1234);
    #1;
    check_eq("rw_wait1", m1_waitrequest, 0);
    check_eq("rw_we", mem_write, 1);
    check_eq("rw_be", mem_byteenable, 32'h3);
    check_eq("rw_wdata", mem_writedata, 32'h0000_1234);
    step();
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("rw_rdv1", m1_readdatavalid, 0);
    check_eq("rw_rdv0", m0_readdatavalid, 0);
    step();
    set_m1(1, 0, 16'h0020, 4'hF, 32'h0);
    step();
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("rw_back_rdv", m1_readdatavalid, 1);
    check_eq("rw_back_data", m1_readdata, 32'hCAFE_1234);
    step();

    // Reset in the cycle after a read accept drops the read.
    set_m0(1, 0, 16'h0001, 4'hF, 32'h0);
    #1;
    check_eq("mr_wait0", m0_waitrequest, 0);
    step();
    set_m0(0, 0, 16'h0, 4'h0, 32'h0);
    reset = 1'b1;
    #1;
    check_eq("mr_rdv0", m0_readdatavalid, 0);
    check_eq("mr_rdv1", m1_readdatavalid, 0);
    step();
    reset = 1'b0;
    #1;
    check_eq("mr_after_rdv0", m0_readdatavalid, 0);
    set_m1(1, 0, 16'h0002, 4'hF, 32'h0);
    #1;
    check_eq("mr_next_wait1", m1_waitrequest, 0);
    check_eq("mr_next_cs", mem_chipselect, 1);
    step();
    set_m1(0, 0, 16'h0, 4'h0, 32'h0);
    #1;
    check_eq("mr_next_rdv1", m1_readdatavalid, 1);
    check_eq("mr_next_data", m1_readdata, 32'hB0B0_0002);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
